// File: rtl/operation_r.sv
// operation_r: primitive-recursion sequencer.
// Computes f(x,0)=g(x), f(x,i+1)=h(x,i,f(x,i)) by handshaking with external
// base (g) and step (h) function blocks.
// Ports:
//   CLK, RST            clock, async active-low reset
//   ST, X, Y            start request and operands (sampled in IDLE only)
//   RD, RES             result-ready level and registered result
//   G_ST/G_IN0/G_RD/G_RES              handshake to g(x)
//   H_ST/H_IN0..2/H_RD/H_RES           handshake to h(x,i,acc)
module operation_r #(
  parameter int unsigned BW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  input  logic [BW-1:0] X,
  input  logic [BW-1:0] Y,
  output logic          RD,
  output logic [BW-1:0] RES,
  output logic          G_ST,
  output logic [BW-1:0] G_IN0,
  input  logic          G_RD,
  input  logic [BW-1:0] G_RES,
  output logic          H_ST,
  output logic [BW-1:0] H_IN0,
  output logic [BW-1:0] H_IN1,
  output logic [BW-1:0] H_IN2,
  input  logic          H_RD,
  input  logic [BW-1:0] H_RES
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    G_START = 3'd1,
    G_SYNC  = 3'd2,
    G_WAIT  = 3'd3,
    H_START = 3'd4,
    H_SYNC  = 3'd5,
    H_WAIT  = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t        state;
  logic [BW-1:0] xr;
  logic [BW-1:0] yr;
  logic [BW-1:0] i;
  logic [BW-1:0] acc;
  logic [BW-1:0] i_inc;

  // Loop exits exactly at yr, so the increment never needs to wrap past it.
  assign i_inc = i + BW'(1);

  // Sub-block operands are the registers themselves, stable for the whole call.
  assign G_IN0 = xr;
  assign H_IN0 = xr;
  assign H_IN1 = i;
  assign H_IN2 = acc;

  // Sequencer: start strobes are raised on the edge entering the START state
  // so they are high exactly while in that state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      i     <= '0;
      acc   <= '0;
      RD    <= 1'b0;
      RES   <= '0;
      G_ST  <= 1'b0;
      H_ST  <= 1'b0;
    end else begin
      G_ST <= 1'b0;
      H_ST <= 1'b0;
      case (state)
        IDLE: begin
          if (ST) begin
            xr    <= X;
            yr    <= Y;
            RD    <= 1'b0;
            G_ST  <= 1'b1;
            state <= G_START;
          end
        end
        G_START: state <= G_SYNC;
        G_SYNC:  state <= G_WAIT;
        G_WAIT: begin
          if (G_RD) begin
            acc <= G_RES;
            i   <= '0;
            if (yr == '0) begin
              state <= DONE;
            end else begin
              H_ST  <= 1'b1;
              state <= H_START;
            end
          end
        end
        H_START: state <= H_SYNC;
        H_SYNC:  state <= H_WAIT;
        H_WAIT: begin
          if (H_RD) begin
            acc <= H_RES;
            i   <= i_inc;
            if (i_inc == yr) begin
              state <= DONE;
            end else begin
              H_ST  <= 1'b1;
              state <= H_START;
            end
          end
        end
        DONE: begin
          RES   <= acc;
          RD    <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/operation_r.md
OPERATION_R -- requirements
Module: operation_r

Interface
REQ-001 SHALL have parameter BW, default 16, data width of all value ports.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ST  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port X  input  BW  non-recursive argument x.
REQ-006 SHALL have port Y  input  BW  recursion count y.
REQ-007 SHALL have port RD  output  1  result-ready level.
REQ-008 SHALL have port RES  output  BW  result f(x,y), registered.
REQ-009 SHALL have ports G_ST out 1, G_IN0 out BW, G_RD in 1, G_RES in BW: handshake to the base function g(x).
REQ-010 SHALL have ports H_ST out 1, H_IN0 out BW, H_IN1 out BW, H_IN2 out BW, H_RD in 1, H_RES in BW: handshake to the step function h(x,i,acc).

Function
REQ-011 SHALL compute primitive recursion: f(x,0)=g(x); f(x,i+1)=h(x,i,f(x,i)).
REQ-012 SHALL implement FSM states IDLE, G_START, G_SYNC, G_WAIT, H_START, H_SYNC, H_WAIT, DONE.
REQ-013 IDLE: ST=1 at an edge SHALL latch X->xr, Y->yr, clear RD, go to G_START; ST=0 stays in IDLE.
REQ-014 G_START SHALL drive G_ST=1 for exactly one cycle, then go to G_SYNC.
REQ-015 G_SYNC SHALL last one cycle, ignoring G_RD, then go to G_WAIT.
REQ-016 G_WAIT SHALL hold until G_RD=1, then load acc<=G_RES and i<=0; go to DONE if yr=0, else to H_START.
REQ-017 H_START SHALL drive H_ST=1 for exactly one cycle; H_SYNC SHALL last one cycle, ignoring H_RD.
REQ-018 H_WAIT SHALL hold until H_RD=1, then load acc<=H_RES and i<=i+1; go to DONE if i+1=yr, else to H_START.
REQ-019 DONE SHALL load RES<=acc and set RD=1, then return to IDLE.
REQ-020 RD and RES SHALL hold until the next accepted ST; RD SHALL clear on the edge that accepts ST.
REQ-021 G_IN0=H_IN0=xr, H_IN1=i, H_IN2=acc SHALL be registered and stable from each *_START through *_WAIT exit.
REQ-022 ST outside IDLE, including in DONE, SHALL be ignored; X/Y changes after acceptance SHALL have no effect.
REQ-023 i SHALL be BW bits, and the i+1=yr compare SHALL never wrap, because the loop exits at yr.
REQ-024 acc SHALL take H_RES/G_RES verbatim; overflow behaviour belongs to g/h.
REQ-025 With sub-blocks raising RD in the cycle after their SYNC state, RD SHALL rise 4+3*y cycles after the ST-accepting edge.
REQ-026 G_ST and H_ST SHALL never both be 1 and SHALL never be 1 outside their START states.

Reset
REQ-027 RST=0 SHALL immediately force the IDLE state, RD=0, RES=0, G_ST=0, H_ST=0, xr=yr=i=acc=0, regardless of the clock.
REQ-028 Reset mid-operation SHALL abandon the computation; the first ST after RST returns to 1 starts a fresh run.

Verification
REQ-029 Bench models: g returns G_IN0, and h returns H_IN2+1 mod 2^BW; both raise RD one cycle after their SYNC state.
REQ-030 X=5, Y=0, ST pulse -> RES=5, RD=1 at 4 cycles, and H_ST is never asserted.
REQ-031 X=3, Y=4 -> RES=7, RD=1 at 16 cycles; H_IN1 shows 0,1,2,3 and H_IN2 shows 3,4,5,6 across the four H_ST pulses.
REQ-032 X=16'hFFFF, Y=1 -> RES=0, RD=1 at 7 cycles (wrap delegated to h).
REQ-033 X=2, Y=3, ST re-pulsed while busy and X/Y changed -> RES=5 unaffected; a subsequent ST in IDLE with X=1, Y=1 -> RES=2.
REQ-034 X=3, Y=4 with RST=0 asserted between clock edges during H_WAIT -> RD, RES, H_ST and G_ST are 0 immediately; after release, X=0, Y=2 -> RES=2.
